// File: rtl/cellrv32_cpu_cp_fpu32_i2f_if.sv
// Handshake and data bundle between the FPU control engine (master) and the
// int-to-float converter (slave).
interface cellrv32_cpu_cp_fpu32_i2f_if;
  logic        start_i;
  logic [2:0]  rmode_i;
  logic        funct_i;
  logic [31:0] int_i;
  logic [31:0] result_o;
  logic [4:0]  flags_o;
  logic        done_o;

  modport master (
    output start_i, rmode_i, funct_i, int_i,
    input  result_o, flags_o, done_o
  );

  modport slave (
    input  start_i, rmode_i, funct_i, int_i,
    output result_o, flags_o, done_o
  );
endinterface

// File: rtl/cellrv32_cpu_cp_fpu32_i2f.sv
// Multi-cycle int-to-float converter (FCVT.S.W / FCVT.S.WU): bit-serial
// normalization followed by one rounding step in the captured rounding mode.
module cellrv32_cpu_cp_fpu32_i2f #(
  parameter int XLEN = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  cellrv32_cpu_cp_fpu32_i2f_if.slave   bus
);

  localparam int FP_EXC_NV_C = 4;
  localparam int FP_EXC_DZ_C = 3;
  localparam int FP_EXC_OF_C = 2;
  localparam int FP_EXC_UF_C = 1;
  localparam int FP_EXC_NX_C = 0;

  localparam logic [7:0] EXP_START = 8'(127 + XLEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREPARE,
    S_NORMALIZE,
    S_ROUND,
    S_FINALIZE
  } state_t;

  state_t                   state_q, state_d;
  logic signed [XLEN-1:0]   int_q, int_d;
  logic                     funct_q, funct_d;
  logic [2:0]               rmode_q, rmode_d;
  logic                     sign_q, sign_d;
  logic [XLEN-1:0]          mag_q, mag_d;
  logic [7:0]               exp_q, exp_d;
  logic [22:0]              man_q, man_d;
  logic                     zero_q, zero_d;
  logic                     nx_q, nx_d;
  logic [31:0]              result_q, result_d;
  logic [4:0]               flags_q, flags_d;
  logic                     done_q, done_d;

  logic                     rnd_en;
  logic [23:0]              man_sum;

  // Round-up decision from the kept LSB and guard/round/sticky bits.
  function automatic logic round_up(input logic [2:0] rm, input logic sgn,
                                    input logic lsb, input logic g,
                                    input logic r, input logic s);
    logic inexact;
    inexact = g | r | s;
    case (rm)
      3'b000:  round_up = g & (r | s | lsb);
      3'b001:  round_up = 1'b0;
      3'b010:  round_up = sgn & inexact;
      3'b011:  round_up = ~sgn & inexact;
      3'b100:  round_up = g;
      default: round_up = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    int_d    = int_q;
    funct_d  = funct_q;
    rmode_d  = rmode_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    exp_d    = exp_q;
    man_d    = man_q;
    zero_d   = zero_q;
    nx_d     = nx_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    rnd_en   = 1'b0;
    man_sum  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          int_d   = bus.int_i;
          funct_d = bus.funct_i;
          rmode_d = bus.rmode_i;
          state_d = S_PREPARE;
        end
      end

      S_PREPARE: begin
        sign_d = ~funct_q & int_q[XLEN-1];
        // Negating INT_MIN wraps back to 0x80000000, which is the correct magnitude.
        mag_d  = sign_d ? $unsigned(-int_q) : $unsigned(int_q);
        exp_d  = EXP_START;
        man_d  = '0;
        nx_d   = 1'b0;
        zero_d = (mag_d == '0);
        state_d = zero_d ? S_FINALIZE : S_NORMALIZE;
      end

      S_NORMALIZE: begin
        if (!mag_q[XLEN-1]) begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 8'd1;
        end else begin
          state_d = S_ROUND;
        end
      end

      S_ROUND: begin
        rnd_en  = round_up(rmode_q, sign_q, mag_q[8], mag_q[7], mag_q[6], |mag_q[5:0]);
        man_sum = {1'b0, mag_q[30:8]} + {23'b0, rnd_en};
        nx_d    = |mag_q[7:0];
        // Mantissa overflow renormalizes; exponent tops out at 159, far from inf.
        if (man_sum[23]) begin
          man_d = '0;
          exp_d = exp_q + 8'd1;
        end else begin
          man_d = man_sum[22:0];
        end
        state_d = S_FINALIZE;
      end

      S_FINALIZE: begin
        result_d = zero_q ? 32'h0 : {sign_q, exp_q, man_q};
        flags_d  = '0;
        flags_d[FP_EXC_NX_C] = nx_q;
        flags_d[FP_EXC_NV_C] = 1'b0;
        flags_d[FP_EXC_DZ_C] = 1'b0;
        flags_d[FP_EXC_OF_C] = 1'b0;
        flags_d[FP_EXC_UF_C] = 1'b0;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      int_q    <= '0;
      funct_q  <= 1'b0;
      rmode_q  <= '0;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      exp_q    <= '0;
      man_q    <= '0;
      zero_q   <= 1'b0;
      nx_q     <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      int_q    <= int_d;
      funct_q  <= funct_d;
      rmode_q  <= rmode_d;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      exp_q    <= exp_d;
      man_q    <= man_d;
      zero_q   <= zero_d;
      nx_q     <= nx_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.flags_o  = flags_q;
  assign bus.done_o   = done_q;

endmodule

// File: tb/tb_cellrv32_cpu_cp_fpu32_i2f.sv
// Bench for the int-to-float converter: directed corner cases plus randomized
// operands checked against an arithmetic (quotient/remainder) rounding model.
module tb_cellrv32_cpu_cp_fpu32_i2f;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  cellrv32_cpu_cp_fpu32_i2f_if bus_if ();

  cellrv32_cpu_cp_fpu32_i2f #(.XLEN(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact magnitude split into kept quotient and discarded remainder.
  function automatic void ref_i2f(input logic [31:0] x, input logic f, input logic [2:0] rm,
                                  output logic [31:0] res, output logic nx, output int lat);
    logic s;
    longint unsigned mag, q, rem, half;
    int p, sh, e;
    logic up;
    s   = !f && x[31];
    mag = s ? (64'h1_0000_0000 - {32'h0, x}) : {32'h0, x};
    nx  = 1'b0;
    res = 32'h0;
    if (mag == 0) begin
      lat = 2;
      return;
    end
    p = 0;
    for (int i = 0; i < 32; i++) if (((mag >> i) & 64'd1) != 0) p = i;
    lat = 4 + (31 - p);
    e   = 127 + p;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 64'd1 << (sh - 1);
      nx   = (rem != 0);
      case (rm)
        3'd0:    up = (rem > half) || ((rem == half) && q[0]);
        3'd1:    up = 1'b0;
        3'd2:    up = s && (rem != 0);
        3'd3:    up = !s && (rem != 0);
        3'd4:    up = (rem >= half);
        default: up = 1'b0;
      endcase
      q = q + {63'd0, up};
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    res = {s, e[7:0], q[22:0]};
  endfunction

  // Issue one conversion; scramble the inputs after capture so only the
  // sampled operand may influence the result. Returns at the done cycle.
  task automatic convert(input logic [31:0] x, input logic f, input logic [2:0] rm,
                         output logic [31:0] res, output logic [4:0] fl, output int lat);
    bus_if.int_i   = x;
    bus_if.funct_i = f;
    bus_if.rmode_i = rm;
    bus_if.start_i = 1'b1;
    @(posedge clk); #1;
    bus_if.start_i = 1'b0;
    bus_if.int_i   = $urandom;
    bus_if.funct_i = 1'($urandom);
    bus_if.rmode_i = 3'($urandom);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (bus_if.done_o) begin
        lat = n;
        break;
      end
    end
    res = bus_if.result_o;
    fl  = bus_if.flags_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.start_i = 1'b0;
    bus_if.int_i   = '0;
    bus_if.funct_i = 1'b0;
    bus_if.rmode_i = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus_if.result_o !== 32'h0) begin
      bad++; $display("FAIL reset_result got=%h exp=%h", bus_if.result_o, 32'h0);
    end
    total++;
    if (bus_if.flags_o !== 5'h0) begin
      bad++; $display("FAIL reset_flags got=%h exp=%h", bus_if.flags_o, 5'h0);
    end
    total++;
    if (bus_if.done_o !== 1'b0) begin
      bad++; $display("FAIL reset_done got=%b exp=0", bus_if.done_o);
    end
    rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0] x;
    logic        f;
    logic [2:0]  rm;
    logic [31:0] res;
    logic        nx;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[12];
    logic [31:0] r;
    logic [4:0]  fl;
    int          lat;
    v[0]  = '{32'h0000_0001, 1'b0, 3'd0, 32'h3F80_0000, 1'b0, 35};
    v[1]  = '{32'hFFFF_FFFF, 1'b0, 3'd0, 32'hBF80_0000, 1'b0, 35};
    v[2]  = '{32'h0100_0001, 1'b0, 3'd0, 32'h4B80_0000, 1'b1, 11};
    v[3]  = '{32'h0100_0001, 1'b0, 3'd3, 32'h4B80_0001, 1'b1, 11};
    v[4]  = '{32'h0100_0001, 1'b0, 3'd1, 32'h4B80_0000, 1'b1, 11};
    v[5]  = '{32'hFFFF_FFFF, 1'b1, 3'd0, 32'h4F80_0000, 1'b1, 4};
    v[6]  = '{32'hFFFF_FFFF, 1'b0, 3'd2, 32'hBF80_0000, 1'b0, 35};
    v[7]  = '{32'h8000_0000, 1'b0, 3'd0, 32'hCF00_0000, 1'b0, 4};
    v[8]  = '{32'h0000_0000, 1'b0, 3'd0, 32'h0000_0000, 1'b0, 2};
    v[9]  = '{32'h0000_0000, 1'b0, 3'd2, 32'h0000_0000, 1'b0, 2};
    v[10] = '{32'h0100_0001, 1'b0, 3'd4, 32'h4B80_0001, 1'b1, 11};
    v[11] = '{32'h0100_0001, 1'b0, 3'd5, 32'h4B80_0000, 1'b1, 11};
    for (int i = 0; i < 12; i++) begin
      convert(v[i].x, v[i].f, v[i].rm, r, fl, lat);
      total++;
      if (r !== v[i].res) begin
        bad++; $display("FAIL dir%0d_result got=%h exp=%h", i, r, v[i].res);
      end
      total++;
      if (fl !== {4'b0, v[i].nx}) begin
        bad++; $display("FAIL dir%0d_flags got=%h exp=%h", i, fl, {4'b0, v[i].nx});
      end
      total++;
      if (lat != v[i].lat) begin
        bad++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, v[i].lat);
      end
      @(posedge clk); #1;
      total++;
      if (bus_if.done_o !== 1'b0 || bus_if.result_o !== v[i].res) begin
        bad++; $display("FAIL dir%0d_hold done=%b result=%h exp done=0 result=%h",
                        i, bus_if.done_o, bus_if.result_o, v[i].res);
      end
    end
  endtask

  task automatic run_random(input string name, input int count, input bit gaps);
    logic [31:0] x, r, er;
    logic [4:0]  fl;
    logic        f, enx;
    logic [2:0]  rm;
    int          lat, elat;
    for (int i = 0; i < count; i++) begin
      x  = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) x = 32'h0;
      f  = 1'($urandom);
      if (!f && $urandom_range(0, 1) == 1) x = -x;
      rm = 3'($urandom_range(0, 7));
      ref_i2f(x, f, rm, er, enx, elat);
      if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      convert(x, f, rm, r, fl, lat);
      total++;
      if (r !== er || fl !== {4'b0, enx} || lat != elat) begin
        bad++;
        $display("FAIL %s%0d in=%h f=%b rm=%0d got res=%h fl=%h lat=%0d exp res=%h fl=%h lat=%0d",
                 name, i, x, f, rm, r, fl, lat, er, {4'b0, enx}, elat);
      end
    end
  endtask

  task automatic test_random();
    run_random("rand", 60, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_random("b2b", 20, 1'b0);
  endtask

  task automatic test_busy_start();
    int dones, lat;
    logic [31:0] r;
    bus_if.int_i   = 32'h0000_0001;
    bus_if.funct_i = 1'b0;
    bus_if.rmode_i = 3'd0;
    bus_if.start_i = 1'b1;
    @(posedge clk); #1;
    bus_if.start_i = 1'b0;
    dones = 0;
    lat   = -1;
    r     = 32'h0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      bus_if.start_i = 1'b0;
      if (n == 3 || n == 20) begin
        bus_if.int_i   = 32'h7FFF_FFFF;
        bus_if.funct_i = 1'b1;
        bus_if.rmode_i = 3'd3;
        bus_if.start_i = 1'b1;
      end
      if (bus_if.done_o) begin
        dones++;
        if (lat < 0) begin
          lat = n;
          r   = bus_if.result_o;
        end
      end
    end
    bus_if.start_i = 1'b0;
    total++;
    if (dones != 1) begin
      bad++; $display("FAIL busy_done_count got=%0d exp=1", dones);
    end
    total++;
    if (r !== 32'h3F80_0000 || lat != 35) begin
      bad++; $display("FAIL busy_result got=%h lat=%0d exp=%h lat=35", r, lat, 32'h3F80_0000);
    end
  endtask

  task automatic test_reset_abort();
    int dones, lat;
    logic [31:0] r;
    logic [4:0]  fl;
    convert(32'h0100_0001, 1'b0, 3'd3, r, fl, lat);
    bus_if.int_i   = 32'h0000_0001;
    bus_if.funct_i = 1'b0;
    bus_if.rmode_i = 3'd0;
    bus_if.start_i = 1'b1;
    @(posedge clk); #1;
    bus_if.start_i = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (bus_if.result_o !== 32'h0 || bus_if.flags_o !== 5'h0 || bus_if.done_o !== 1'b0) begin
      bad++; $display("FAIL abort_clear result=%h flags=%h done=%b exp 0/0/0",
                      bus_if.result_o, bus_if.flags_o, bus_if.done_o);
    end
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (bus_if.done_o) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++; $display("FAIL abort_no_done got=%0d exp=0", dones);
    end
    convert(32'hFFFF_FF00, 1'b0, 3'd0, r, fl, lat);
    total++;
    if (r !== 32'hC380_0000 || fl !== 5'h0 || lat != 27) begin
      bad++; $display("FAIL abort_recover got res=%h fl=%h lat=%0d exp res=%h fl=0 lat=27",
                      r, fl, lat, 32'hC380_0000);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_busy_start();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
